i2c_sensor_target: RTL and testbench

//  I2C target (slave) responder that emulates one polled 16-bit sensor on the shared sda/scl bus.

---
 rtl/i2c_sensor_target.sv | 190 +++++++++++++++++++
 tb/tb_i2c_sensor_target.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_sensor_target.sv
// rtl/i2c_sensor_target.sv - I2C target emulating one polled 16-bit sensor
//
// Answers 2-byte reads of TARGET_ADDR with tx_data (MSB first, latched once per
// read) and accepts 2-byte writes into rx_data.
//
// Ports:
//   clk       system clock, at least 8x the SCL rate
//   rst       synchronous active-high reset
//   scl       bus clock, input only (no clock stretching)
//   sda       bus data, open-drain: driven 1'b0 or released (z)
//   tx_data   sensor value returned on reads
//   rx_data   last complete 2-byte write, {first byte, second byte}
//   rx_valid  one-cycle pulse when rx_data updates
//   busy      high from address-match ACK until STOP/START
module i2c_sensor_target #(
  parameter logic [6:0] TARGET_ADDR = 7'b1001000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  inout  wire         sda,
  input  logic [15:0] tx_data,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, TX_BYTE, TX_ACK, RX_BYTE, RX_ACK
  } state_t;

  state_t      state;
  logic        scl_s1, scl_s2, scl_prev;
  logic        sda_s1, sda_s2, sda_prev;
  logic        sda_oe;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;
  logic [7:0]  rx_b1;
  logic [15:0] shadow;
  logic        rw;
  logic        byte_sel;
  logic [1:0]  rx_count;

  assign sda = sda_oe ? 1'b0 : 1'bz;

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_s2 & ~scl_prev;
  assign scl_fall  = ~scl_s2 & scl_prev;
  assign start_det = scl_s2 & scl_prev & sda_prev & ~sda_s2;
  assign stop_det  = scl_s2 & scl_prev & ~sda_prev & sda_s2;

  // Byte currently being shifted out, and the one that follows it.
  logic [7:0] cur_byte, next_byte;
  logic [2:0] bit_idx;
  assign cur_byte  = byte_sel ? shadow[7:0] : shadow[15:8];
  assign next_byte = byte_sel ? shadow[15:8] : shadow[7:0];
  assign bit_idx   = 3'd7 - bit_cnt[2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      scl_s1   <= 1'b1;
      scl_s2   <= 1'b1;
      scl_prev <= 1'b1;
      sda_s1   <= 1'b1;
      sda_s2   <= 1'b1;
      sda_prev <= 1'b1;
      sda_oe   <= 1'b0;
      bit_cnt  <= 4'd0;
      shift    <= 8'd0;
      rx_b1    <= 8'd0;
      shadow   <= 16'd0;
      rw       <= 1'b0;
      byte_sel <= 1'b0;
      rx_count <= 2'd0;
      rx_data  <= 16'd0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      scl_s1   <= scl;
      scl_s2   <= scl_s1;
      scl_prev <= scl_s2;
      sda_s1   <= sda;
      sda_s2   <= sda_s1;
      sda_prev <= sda_s2;
      rx_valid <= 1'b0;

      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR: if (scl_rise) begin
            shift   <= {shift[6:0], sda_s2};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              // shift[6:0] holds the address; this bit is R/W.
              rw      <= sda_s2;
              bit_cnt <= 4'd0;
              state   <= (shift[6:0] == TARGET_ADDR) ? ADDR_ACK : IDLE;
            end
          end
          // bit_cnt 0: waiting for the fall that opens the ACK slot;
          // bit_cnt 1: ACK is on the bus, waiting for the fall that closes it.
          ADDR_ACK: if (scl_fall) begin
            if (bit_cnt == 4'd0) begin
              sda_oe   <= 1'b1;
              busy     <= 1'b1;
              shadow   <= tx_data;
              byte_sel <= 1'b0;
              rx_count <= 2'd0;
              bit_cnt  <= 4'd1;
            end else begin
              bit_cnt <= 4'd0;
              if (rw) begin
                sda_oe <= ~shadow[15];
                state  <= TX_BYTE;
              end else begin
                sda_oe <= 1'b0;
                state  <= RX_BYTE;
              end
            end
          end
          TX_BYTE: begin
            if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= TX_ACK;
              end else if (bit_cnt != 4'd0) begin
                sda_oe <= ~cur_byte[bit_idx];
              end
            end
          end
          TX_ACK: begin
            if (scl_rise) begin
              if (sda_s2) state <= IDLE;
              else        bit_cnt <= 4'd1;
            end
            if (scl_fall && bit_cnt == 4'd1) begin
              byte_sel <= ~byte_sel;
              sda_oe   <= ~next_byte[7];
              bit_cnt  <= 4'd0;
              state    <= TX_BYTE;
            end
          end
          RX_BYTE: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda_s2};
              bit_cnt <= bit_cnt + 4'd1;
            end
            if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              if (rx_count == 2'd0) rx_b1 <= shift;
              if (rx_count != 2'd2) begin
                sda_oe <= 1'b1;
                state  <= RX_ACK;
              end else begin
                state <= IDLE;
              end
            end
          end
          RX_ACK: begin
            if (scl_rise) bit_cnt <= 4'd1;
            if (scl_fall && bit_cnt == 4'd1) begin
              sda_oe   <= 1'b0;
              bit_cnt  <= 4'd0;
              rx_count <= rx_count + 2'd1;
              state    <= RX_BYTE;
              if (rx_count == 2'd1) begin
                rx_data  <= {rx_b1, shift};
                rx_valid <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_sensor_target.sv
// tb/tb_i2c_sensor_target.sv - self-checking bench for i2c_sensor_target
`timescale 1ns/1ps
module tb_i2c_sensor_target;

  localparam int Q = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        m_low = 1'b0;
  logic [15:0] tx_data = 16'd0;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        busy;
  wire         sda;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_sensor_target #(.TARGET_ADDR(7'h48)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  always @(posedge clk) if (rx_valid === 1'b1) pulses <= pulses + 1;

  // Reference model state
  logic [15:0] m_rx = 16'd0;
  int          m_pulses = 0;

  task automatic i2c_start();
    m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #(2*Q);
  endtask

  task automatic write_bit(input logic b);
    m_low = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0; #Q; scl = 1'b1; #Q; b = sda; #Q; scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic give_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin read_bit(b); d[i] = b; end
    write_bit(~give_ack);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++; if (rx_data !== 16'd0) begin fails++; $display("FAIL reset_rx_data got=%h exp=0000", rx_data); end
    tests++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin fails++; $display("FAIL reset_flags busy=%b rx_valid=%b exp=0", busy, rx_valid); end
    tests++; if (sda !== 1'b1) begin fails++; $display("FAIL reset_sda got=%b exp=1(released)", sda); end
    @(negedge clk) rst = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_read();
    logic ack; logic [7:0] b;
    tx_data = 16'h1980;
    i2c_start();
    write_byte({7'h48, 1'b1}, ack);
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL read_addr_ack got=%b exp=0", ack); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL read_busy got=%b exp=1", busy); end
    read_byte(b, 1'b1);
    tests++; if (b !== 8'h19) begin fails++; $display("FAIL read_hi got=%h exp=19", b); end
    read_byte(b, 1'b0);
    tests++; if (b !== 8'h80) begin fails++; $display("FAIL read_lo got=%h exp=80", b); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL read_busy_before_stop got=%b exp=1", busy); end
    i2c_stop();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL read_busy_after_stop got=%b exp=0", busy); end
  endtask

  task automatic test_read_nomatch();
    logic ack; logic [7:0] b;
    i2c_start();
    write_byte({7'h49, 1'b1}, ack);
    tests++; if (ack !== 1'b1) begin fails++; $display("FAIL nomatch_ack got=%b exp=1", ack); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL nomatch_busy got=%b exp=0", busy); end
    read_byte(b, 1'b0);
    tests++; if (b !== 8'hFF) begin fails++; $display("FAIL nomatch_data got=%h exp=ff", b); end
    i2c_stop();
  endtask

  task automatic test_write();
    logic a0, a1, a2, a3;
    int p0;
    p0 = pulses;
    i2c_start();
    write_byte({7'h48, 1'b0}, a0);
    write_byte(8'hA5, a1);
    write_byte(8'h3C, a2);
    write_byte(8'h11, a3);
    i2c_stop();
    tests++; if ({a0, a1, a2} !== 3'b000) begin fails++; $display("FAIL write_acks got=%b exp=000", {a0, a1, a2}); end
    tests++; if (a3 !== 1'b1) begin fails++; $display("FAIL write_third_nack got=%b exp=1", a3); end
    tests++; if (rx_data !== 16'hA53C) begin fails++; $display("FAIL write_rx_data got=%h exp=a53c", rx_data); end
    tests++; if (pulses - p0 !== 1) begin fails++; $display("FAIL write_pulses got=%0d exp=1", pulses - p0); end
    m_rx = 16'hA53C;
    m_pulses = pulses;
  endtask

  task automatic test_reset_mid_ack();
    logic [7:0] a;
    a = {7'h48, 1'b0};
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(a[i]);
    m_low = 1'b0; #Q;
    tests++; if (sda !== 1'b0) begin fails++; $display("FAIL midack_driven got=%b exp=0", sda); end
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    tests++; if (sda !== 1'b1) begin fails++; $display("FAIL midack_release got=%b exp=1", sda); end
    repeat (2) @(posedge clk);
    #1;
    tests++; if (rx_data !== 16'd0 || busy !== 1'b0) begin fails++; $display("FAIL midack_state rx_data=%h busy=%b exp=0000,0", rx_data, busy); end
    @(negedge clk) rst = 1'b0;
    m_rx = 16'd0;
    #Q;
    i2c_stop();
    m_pulses = pulses;
  endtask

  task automatic test_tx_coherent();
    logic ack; logic [7:0] b0, b1;
    tx_data = 16'h1980;
    i2c_start();
    write_byte({7'h48, 1'b1}, ack);
    tx_data = 16'hFFFF;
    read_byte(b0, 1'b1);
    read_byte(b1, 1'b0);
    i2c_stop();
    tests++; if ({ack, b0, b1} !== {1'b0, 8'h19, 8'h80}) begin fails++; $display("FAIL coherent got=%b,%h,%h exp=0,19,80", ack, b0, b1); end
  endtask

  task automatic test_read_wrap();
    logic ack; logic [7:0] b0, b1, b2;
    tx_data = 16'h1980;
    i2c_start();
    write_byte({7'h48, 1'b1}, ack);
    read_byte(b0, 1'b1);
    read_byte(b1, 1'b1);
    read_byte(b2, 1'b0);
    i2c_stop();
    tests++; if ({b0, b1, b2} !== 24'h198019) begin fails++; $display("FAIL wrap got=%h%h%h exp=198019", b0, b1, b2); end
  endtask

  task automatic test_restart();
    logic a0, a1; logic [7:0] b0, b1; logic [15:0] v;
    i2c_start();
    write_byte({7'h48, 1'b0}, a0);
    for (int i = 0; i < 4; i++) write_bit(i[0]);
    v = 16'($urandom);
    tx_data = v;
    i2c_start();
    write_byte({7'h48, 1'b1}, a1);
    read_byte(b0, 1'b1);
    read_byte(b1, 1'b0);
    i2c_stop();
    tests++; if ({a0, a1} !== 2'b00) begin fails++; $display("FAIL restart_acks got=%b exp=00", {a0, a1}); end
    tests++; if ({b0, b1} !== v) begin fails++; $display("FAIL restart_data got=%h%h exp=%h", b0, b1, v); end
    tests++; if (rx_data !== m_rx || pulses !== m_pulses) begin fails++; $display("FAIL restart_rx rx_data=%h pulses=%0d exp=%h,%0d", rx_data, pulses, m_rx, m_pulses); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 16; t++) begin
      logic match, rw, ack, exp_ack;
      logic [6:0] addr;
      logic [15:0] v;
      logic [7:0] b, exp_b;
      logic [7:0] d [3];
      int n;
      match = ($urandom_range(0, 3) != 0);
      addr = match ? 7'h48 : 7'($urandom_range(0, 127));
      if (addr == 7'h48) match = 1'b1;
      rw = 1'($urandom);
      i2c_start();
      write_byte({addr, rw}, ack);
      tests++; if (ack !== ~match) begin fails++; $display("FAIL rnd%0d_addr_ack got=%b exp=%b", t, ack, ~match); end
      if (rw) begin
        n = $urandom_range(1, 3);
        v = tx_data;
        if ($urandom_range(0, 1) == 1) tx_data = 16'($urandom);
        for (int i = 0; i < n; i++) begin
          read_byte(b, i < n - 1);
          exp_b = !match ? 8'hFF : ((i % 2 == 0) ? v[15:8] : v[7:0]);
          tests++; if (b !== exp_b) begin fails++; $display("FAIL rnd%0d_rd%0d got=%h exp=%h", t, i, b, exp_b); end
        end
      end else begin
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
          d[i] = 8'($urandom);
          write_byte(d[i], ack);
          exp_ack = !(match && i < 2);
          tests++; if (ack !== exp_ack) begin fails++; $display("FAIL rnd%0d_wr%0d_ack got=%b exp=%b", t, i, ack, exp_ack); end
        end
        if (match && n >= 2) begin
          m_rx = {d[0], d[1]};
          m_pulses++;
        end
      end
      i2c_stop();
      tests++; if (rx_data !== m_rx || pulses !== m_pulses || busy !== 1'b0) begin
        fails++; $display("FAIL rnd%0d_end rx_data=%h pulses=%0d busy=%b exp=%h,%0d,0", t, rx_data, pulses, busy, m_rx, m_pulses);
      end
      tx_data = 16'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_read_nomatch();
    test_write();
    test_reset_mid_ack();
    test_tx_coherent();
    test_read_wrap();
    test_restart();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
